image_read_scheduler: RTL and testbench
=======================================

# image_read_scheduler

Burst scheduler between the image address FIFO and the DRAM read engine in the pixel-clock domain. Takes one image address range (start/end byte address popped from the image address FIFO), splits it into AXI-legal read bursts, and issues each burst as a `dram_read_addr`/`dram_read_len`/`dram_read_en` command. Commands are throttled by the read engine's busy flag and the image data save buffer's programmable-full flag. This fills the address/length sequencing that the image sender's one-shot read enable leaves open.

## Interface
- `DRAM_ADDR_WIDTH`, 39, DRAM byte-address width.
- `DRAM_DATA_WIDTH`, 128, beat width in bits; bytes per beat `BPB = DRAM_DATA_WIDTH/8` (16).
- `MAX_BURST_LEN`, 256, maximum beats per burst; must be 1..256.

Ports:
- `clk_pixel` in 1: the only clock.
- `image_sender_reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that latches `start_addr`/`end_addr`.
- `start_addr` in 64: first byte address. Only the low `DRAM_ADDR_WIDTH` bits are used.
- `end_addr` in 64: exclusive end byte address. Only the low `DRAM_ADDR_WIDTH` bits are used.
- `abort` in 1: flush; cancels the current range.
- `dram_read_busy` in 1: read engine busy.
- `dram_buffer_full` in 1: save-buffer programmable-full.
- `dram_read_addr` out `DRAM_ADDR_WIDTH`: burst start byte address.
- `dram_read_len` out 8: beats−1.
- `dram_read_en` out 1: one-cycle command strobe.
- `sched_busy` out 1: high whenever state ≠ IDLE.
- `sched_done` out 1: one-cycle pulse when the last burst of a range has been issued.
- `sched_error` out 1: one-cycle pulse when a range is rejected.

## Operation
- States: IDLE, CALC, ISSUE, HOLD, DONE.
- IDLE:
  - `start`=1 with a valid range → latch `cur=start_addr`, `end=end_addr`, go to CALC.
  - A range is invalid if `start_addr[3:0]≠0`, `end_addr[3:0]≠0`, or `end_addr≤start_addr`. An invalid range pulses `sched_error` and stays in IDLE.
- CALC: compute the burst beat count and go to ISSUE.
  - `rem = (end−cur)/BPB`.
  - `beats = min(rem, MAX_BURST_LEN, b4k)`.
  - `b4k = (4096 − cur[11:0])/BPB` when the 4K split is compiled in; otherwise `b4k` is treated as infinite.
  - Arithmetic uses the full `DRAM_ADDR_WIDTH` width; `beats` is 9 bits.
- ISSUE: when `dram_read_busy`=0 and `dram_buffer_full`=0:
  - Drive `dram_read_addr=cur`, `dram_read_len=beats−1`, `dram_read_en=1` for one cycle.
  - Update `cur += beats*BPB`.
  - Go to HOLD. Otherwise wait in ISSUE with `dram_read_en`=0.
- HOLD: exactly one cycle, covering the read engine's busy-assertion latency (busy rises the cycle after `dram_read_en`).
  - Then go to DONE if `cur==end`, else to CALC.
- DONE: pulse `sched_done`, go to IDLE.
- `start` while not in IDLE is ignored (no latch, no error).
- `abort`=1 in any state → IDLE on the next edge.
  - No `dram_read_en` in that cycle. No `sched_done`, no `sched_error`.
  - `abort` takes priority over `start` in the same cycle.
- `dram_read_addr`/`dram_read_len` hold their last issued values between commands.

## Timing
- Reset (asynchronous): state=IDLE; `cur`, `end` = 0; all outputs 0.
- Valid `start` at edge N → CALC at N+1 → first `dram_read_en` at edge N+2, when not throttled.
- Minimum spacing between consecutive `dram_read_en` strobes: 3 cycles (ISSUE→HOLD→CALC→ISSUE).
- `sched_done` asserts 2 cycles after the final `dram_read_en`.
- `sched_error` asserts 1 cycle after the rejected `start`.
- `sched_busy` is high from the cycle after a valid `start` through the DONE cycle inclusive.
- Throttle inputs are sampled only in ISSUE. A deassertion of either throttle input allows `dram_read_en` on that same edge.
- Reset mid-burst: outputs go to 0 immediately; an in-flight DRAM read is not cancelled by this block.

## Configuration
- `IMAGE_READ_4K_SPLIT_EN`:
  - Defined: no burst crosses a 4 KiB address boundary; bursts are split at each 4 KiB line (AXI rule).
  - Undefined: bursts are limited only by `MAX_BURST_LEN` and the remaining length.

## Test plan
- start=0x1000, end=0x1400 → one `dram_read_en`: addr 0x1000, len 63; `sched_done` 2 cycles later.
- start=0x0800, end=0x1800:
  - With `IMAGE_READ_4K_SPLIT_EN` → addr 0x0800 len 127, then addr 0x1000 len 127.
  - Without it → addr 0x0800 len 255, single burst.
- start=0x0, end=0x5000 → bursts at 0x0, 0x1000, 0x2000, 0x3000, 0x4000, each len 255; exactly 5 strobes, then `sched_done`.
- Throttling:
  - `dram_buffer_full`=1 for 10 cycles while in ISSUE → no `dram_read_en`; strobe on the edge after release.
  - Same behaviour with `dram_read_busy` held high.
- start=0x1008 or end≤start → `sched_error` pulse, `sched_busy` stays 0, no `dram_read_en`.
- `abort` after the second burst of the 0x5000 range → IDLE next cycle, no further strobes, no `sched_done`.
- Async reset mid-range → all outputs 0 without a clock edge; a new start=0x0, end=0x100 then issues addr 0 len 15.

Source files
------------

// File: rtl/image_read_scheduler_if.sv
// rtl/image_read_scheduler_if.sv - DRAM read command bus between the burst scheduler and the read engine
interface image_read_scheduler_if #(
  parameter int ADDR_WIDTH = 39
);
  logic [ADDR_WIDTH-1:0] dram_read_addr;
  logic [7:0]            dram_read_len;
  logic                  dram_read_en;
  logic                  dram_read_busy;
  logic                  dram_buffer_full;

  modport master (
    output dram_read_addr,
    output dram_read_len,
    output dram_read_en,
    input  dram_read_busy,
    input  dram_buffer_full
  );

  modport slave (
    input  dram_read_addr,
    input  dram_read_len,
    input  dram_read_en,
    output dram_read_busy,
    output dram_buffer_full
  );
endinterface

// File: rtl/image_read_scheduler.sv
// rtl/image_read_scheduler.sv - splits one image address range into DRAM read bursts
// Optional 4 KiB burst splitting is compiled in with `define IMAGE_READ_4K_SPLIT_EN.
module image_read_scheduler #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int MAX_BURST_LEN   = 256
) (
  input  logic                   clk_pixel,
  input  logic                   image_sender_reset,
  input  logic                   start,
  input  logic [63:0]            start_addr,
  input  logic [63:0]            end_addr,
  input  logic                   abort,
  image_read_scheduler_if.master dram,
  output logic                   sched_busy,
  output logic                   sched_done,
  output logic                   sched_error
);

  localparam int AW   = DRAM_ADDR_WIDTH;
  localparam int BPB  = DRAM_DATA_WIDTH / 8;
  localparam int OFFS = $clog2(BPB);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, HOLD, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cur_q, end_q;
  logic [8:0]    beats_q, beats_calc;
  logic [AW-1:0] addr_q;
  logic [7:0]    len_q;
  logic          en_q, done_q, error_q;

  logic [AW-1:0] req_start, req_end, rem_beats;
  logic          range_ok, throttled;
  logic          latch_go, calc_go, issue_go, done_go, error_go;
  logic          unused_hi;

  assign req_start = start_addr[AW-1:0];
  assign req_end   = end_addr[AW-1:0];
  assign unused_hi = ^{start_addr[63:AW], end_addr[63:AW]};
  assign range_ok  = (req_start[OFFS-1:0] == '0) && (req_end[OFFS-1:0] == '0) &&
                     (req_end > req_start);
  assign throttled = dram.dram_read_busy || dram.dram_buffer_full;
  assign rem_beats = (end_q - cur_q) >> OFFS;

`ifdef IMAGE_READ_4K_SPLIT_EN
  logic [12:0]   page_rem;
  logic [AW-1:0] b4k;
  assign page_rem = 13'd4096 - {1'b0, cur_q[11:0]};
  assign b4k      = AW'(page_rem >> OFFS);
`endif

  always_comb begin
    beats_calc = (rem_beats > AW'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : rem_beats[8:0];
`ifdef IMAGE_READ_4K_SPLIT_EN
    if (AW'(beats_calc) > b4k) beats_calc = b4k[8:0];
`endif
  end

  always_ff @(posedge clk_pixel or posedge image_sender_reset) begin
    if (image_sender_reset) state_q <= IDLE;
    else                    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && range_ok) state_d = CALC;
        CALC:    state_d = ISSUE;
        ISSUE:   if (!throttled) state_d = HOLD;
        // cur_q already reflects the burst issued on the previous edge
        HOLD:    state_d = (cur_q == end_q) ? DONE : CALC;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    latch_go = 1'b0;
    error_go = 1'b0;
    calc_go  = 1'b0;
    issue_go = 1'b0;
    done_go  = 1'b0;
    if (!abort) begin
      latch_go = (state_q == IDLE) && start && range_ok;
      error_go = (state_q == IDLE) && start && !range_ok;
      calc_go  = (state_q == CALC);
      issue_go = (state_q == ISSUE) && !throttled;
      done_go  = (state_q == DONE);
    end
  end

  always_ff @(posedge clk_pixel or posedge image_sender_reset) begin
    if (image_sender_reset) begin
      cur_q   <= '0;
      end_q   <= '0;
      beats_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      en_q    <= issue_go;
      done_q  <= done_go;
      error_q <= error_go;
      if (latch_go) begin
        cur_q <= req_start;
        end_q <= req_end;
      end
      if (calc_go) beats_q <= beats_calc;
      if (issue_go) begin
        addr_q <= cur_q;
        len_q  <= 8'(beats_q - 9'd1);
        cur_q  <= cur_q + (AW'(beats_q) << OFFS);
      end
    end
  end

  assign dram.dram_read_addr = addr_q;
  assign dram.dram_read_len  = len_q;
  assign dram.dram_read_en   = en_q;
  assign sched_busy          = (state_q != IDLE);
  assign sched_done          = done_q;
  assign sched_error         = error_q;

endmodule

// File: tb/tb_image_read_scheduler.sv
// tb/tb_image_read_scheduler.sv - directed bench for image_read_scheduler
module tb_image_read_scheduler;

  logic        clk_pixel = 1'b0;
  logic        image_sender_reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] start_addr = '0;
  logic [63:0] end_addr = '0;
  logic        abort = 1'b0;
  logic        sched_busy, sched_done, sched_error;

  image_read_scheduler_if #(.ADDR_WIDTH(39)) dram_if ();

  image_read_scheduler dut (
    .clk_pixel          (clk_pixel),
    .image_sender_reset (image_sender_reset),
    .start              (start),
    .start_addr         (start_addr),
    .end_addr           (end_addr),
    .abort              (abort),
    .dram               (dram_if.master),
    .sched_busy         (sched_busy),
    .sched_done         (sched_done),
    .sched_error        (sched_error)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  int err_cnt = 0, err_cyc = 0;
  logic [38:0] en_addr[$];
  logic [7:0]  en_len[$];
  int          en_cyc[$];

  always @(posedge clk_pixel) cyc <= cyc + 1;

  always @(negedge clk_pixel) begin
    if (dram_if.dram_read_en) begin
      en_addr.push_back(dram_if.dram_read_addr);
      en_len.push_back(dram_if.dram_read_len);
      en_cyc.push_back(cyc);
    end
    if (sched_done) begin done_cnt++; done_cyc = cyc; end
    if (sched_error) begin err_cnt++; err_cyc = cyc; end
  end

  task automatic clear_log();
    en_addr.delete(); en_len.delete(); en_cyc.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  task automatic pulse_start(input logic [63:0] s, input logic [63:0] e);
    @(negedge clk_pixel);
    start = 1'b1; start_addr = s; end_addr = e; start_cyc = cyc + 1;
    @(negedge clk_pixel); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_pixel); #1;
      if (!sched_busy) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk_pixel);
    #1;
  endtask

  task automatic test_reset();
    #1 image_sender_reset = 1'b1;
    repeat (2) @(negedge clk_pixel);
    n_cmp++; if (dram_if.dram_read_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %0b want 0", dram_if.dram_read_en); end
    n_cmp++; if (dram_if.dram_read_addr !== 39'h0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", dram_if.dram_read_addr); end
    n_cmp++; if (dram_if.dram_read_len !== 8'h0) begin n_bad++; $display("FAIL reset_len: got %0h want 0", dram_if.dram_read_len); end
    n_cmp++; if ({sched_busy, sched_done, sched_error} !== 3'b000) begin n_bad++; $display("FAIL reset_status: got %03b want 000", {sched_busy, sched_done, sched_error}); end
    image_sender_reset = 1'b0;
    repeat (2) @(negedge clk_pixel);
  endtask

  task automatic test_single();
    bit ok;
    clear_log();
    pulse_start(64'h1000, 64'h1400);
    n_cmp++; if (sched_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %0b want 1", sched_busy); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got busy want idle"); end
    n_cmp++; if (en_addr.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", en_addr.size()); end
    if (en_addr.size() >= 1) begin
      n_cmp++; if (en_addr[0] !== 39'h1000) begin n_bad++; $display("FAIL single_addr: got %0h want 1000", en_addr[0]); end
      n_cmp++; if (en_len[0] !== 8'd63) begin n_bad++; $display("FAIL single_len: got %0d want 63", en_len[0]); end
      n_cmp++; if (en_cyc[0] - start_cyc != 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", en_cyc[0] - start_cyc); end
      n_cmp++; if (done_cyc - en_cyc[0] != 2) begin n_bad++; $display("FAIL single_done_delay: got %0d want 2", done_cyc - en_cyc[0]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_4k_split();
    bit ok;
    logic [38:0] x_addr[$];
    logic [7:0]  x_len[$];
`ifdef IMAGE_READ_4K_SPLIT_EN
    x_addr = '{39'h0800, 39'h1000};
    x_len  = '{8'd127, 8'd127};
`else
    x_addr = '{39'h0800};
    x_len  = '{8'd255};
`endif
    clear_log();
    pulse_start(64'h0800, 64'h1800);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL split_timeout: got busy want idle"); end
    n_cmp++; if (en_addr.size() != x_addr.size()) begin n_bad++; $display("FAIL split_count: got %0d want %0d", en_addr.size(), x_addr.size()); end
    for (int i = 0; i < x_addr.size() && i < en_addr.size(); i++) begin
      n_cmp++; if (en_addr[i] !== x_addr[i] || en_len[i] !== x_len[i]) begin n_bad++; $display("FAIL split_burst%0d: got %0h/%0d want %0h/%0d", i, en_addr[i], en_len[i], x_addr[i], x_len[i]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL split_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    pulse_start(64'h0, 64'h5000);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got busy want idle"); end
    n_cmp++; if (en_addr.size() != 5) begin n_bad++; $display("FAIL b2b_count: got %0d want 5", en_addr.size()); end
    for (int i = 0; i < 5 && i < en_addr.size(); i++) begin
      logic [38:0] xa;
      xa = 39'(i) << 12;
      n_cmp++; if (en_addr[i] !== xa || en_len[i] !== 8'd255) begin n_bad++; $display("FAIL b2b_burst%0d: got %0h/%0d want %0h/255", i, en_addr[i], en_len[i], xa); end
      if (i > 0) begin
        n_cmp++; if (en_cyc[i] - en_cyc[i-1] != 3) begin n_bad++; $display("FAIL b2b_spacing%0d: got %0d want 3", i, en_cyc[i] - en_cyc[i-1]); end
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL b2b_done: got %0d want 1", done_cnt); end
    if (en_cyc.size() == 5) begin
      n_cmp++; if (done_cyc - en_cyc[4] != 2) begin n_bad++; $display("FAIL b2b_done_delay: got %0d want 2", done_cyc - en_cyc[4]); end
    end
  endtask

  task automatic test_throttle(input bit use_busy);
    bit ok;
    int release_cyc;
    clear_log();
    if (use_busy) dram_if.dram_read_busy = 1'b1;
    else          dram_if.dram_buffer_full = 1'b1;
    pulse_start(64'h1000, 64'h1100);
    repeat (11) @(negedge clk_pixel);
    n_cmp++; if (en_addr.size() != 0) begin n_bad++; $display("FAIL throttle%0d_held: got %0d strobes want 0", use_busy, en_addr.size()); end
    release_cyc = cyc + 1;
    dram_if.dram_read_busy = 1'b0;
    dram_if.dram_buffer_full = 1'b0;
    wait_idle(ok);
    n_cmp++; if (en_addr.size() != 1) begin n_bad++; $display("FAIL throttle%0d_count: got %0d want 1", use_busy, en_addr.size()); end
    if (en_addr.size() == 1) begin
      n_cmp++; if (en_cyc[0] != release_cyc) begin n_bad++; $display("FAIL throttle%0d_edge: got %0d want %0d", use_busy, en_cyc[0], release_cyc); end
      n_cmp++; if (en_len[0] !== 8'd15) begin n_bad++; $display("FAIL throttle%0d_len: got %0d want 15", use_busy, en_len[0]); end
    end
    n_cmp++; if (done_cnt != 1 || !ok) begin n_bad++; $display("FAIL throttle%0d_done: got %0d want 1", use_busy, done_cnt); end
  endtask

  task automatic test_error();
    logic [63:0] s_v[3];
    logic [63:0] e_v[3];
    s_v = '{64'h1008, 64'h2000, 64'h1000};
    e_v = '{64'h2000, 64'h2000, 64'h1008};
    for (int i = 0; i < 3; i++) begin
      clear_log();
      pulse_start(s_v[i], e_v[i]);
      n_cmp++; if (sched_busy !== 1'b0) begin n_bad++; $display("FAIL error%0d_busy: got %0b want 0", i, sched_busy); end
      repeat (6) @(negedge clk_pixel);
      #1;
      n_cmp++; if (err_cnt != 1 || err_cyc != start_cyc) begin n_bad++; $display("FAIL error%0d_pulse: got %0d at %0d want 1 at %0d", i, err_cnt, err_cyc, start_cyc); end
      n_cmp++; if (en_addr.size() != 0 || done_cnt != 0) begin n_bad++; $display("FAIL error%0d_quiet: got %0d strobes %0d done want 0", i, en_addr.size(), done_cnt); end
    end
  endtask

  task automatic test_abort();
    clear_log();
    pulse_start(64'h0, 64'h5000);
    for (int i = 0; i < 100; i++) begin
      if (en_addr.size() >= 2) break;
      @(negedge clk_pixel); #1;
    end
    n_cmp++; if (en_addr.size() != 2) begin n_bad++; $display("FAIL abort_reach: got %0d strobes want 2", en_addr.size()); end
    abort = 1'b1;
    @(negedge clk_pixel); #1;
    abort = 1'b0;
    n_cmp++; if (sched_busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %0b want 0", sched_busy); end
    repeat (20) @(negedge clk_pixel);
    #1;
    n_cmp++; if (en_addr.size() != 2 || done_cnt != 0 || err_cnt != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d strobes %0d done %0d err want 2/0/0", en_addr.size(), done_cnt, err_cnt); end
    clear_log();
    @(negedge clk_pixel);
    start = 1'b1; abort = 1'b1; start_addr = 64'h1000; end_addr = 64'h1400;
    @(negedge clk_pixel); #1;
    start = 1'b0; abort = 1'b0;
    n_cmp++; if (sched_busy !== 1'b0) begin n_bad++; $display("FAIL abort_prio_busy: got %0b want 0", sched_busy); end
    repeat (6) @(negedge clk_pixel);
    #1;
    n_cmp++; if (en_addr.size() != 0 || err_cnt != 0) begin n_bad++; $display("FAIL abort_prio_quiet: got %0d strobes %0d err want 0/0", en_addr.size(), err_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    clear_log();
    pulse_start(64'h0, 64'h5000);
    for (int i = 0; i < 50; i++) begin
      if (en_addr.size() >= 1) break;
      @(negedge clk_pixel); #1;
    end
    n_cmp++; if (dram_if.dram_read_en !== 1'b1) begin n_bad++; $display("FAIL areset_pre_en: got %0b want 1", dram_if.dram_read_en); end
    #1 image_sender_reset = 1'b1;
    #1;
    n_cmp++; if ({dram_if.dram_read_en, sched_busy, sched_done, sched_error} !== 4'b0000) begin n_bad++; $display("FAIL areset_status: got %04b want 0000", {dram_if.dram_read_en, sched_busy, sched_done, sched_error}); end
    n_cmp++; if (dram_if.dram_read_addr !== 39'h0 || dram_if.dram_read_len !== 8'h0) begin n_bad++; $display("FAIL areset_cmd: got %0h/%0h want 0/0", dram_if.dram_read_addr, dram_if.dram_read_len); end
    @(negedge clk_pixel);
    image_sender_reset = 1'b0;
    clear_log();
    pulse_start(64'h0, 64'h100);
    wait_idle(ok);
    n_cmp++; if (!ok || en_addr.size() != 1) begin n_bad++; $display("FAIL areset_restart_count: got %0d want 1", en_addr.size()); end
    if (en_addr.size() == 1) begin
      n_cmp++; if (en_addr[0] !== 39'h0 || en_len[0] !== 8'd15) begin n_bad++; $display("FAIL areset_restart_burst: got %0h/%0d want 0/15", en_addr[0], en_len[0]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL areset_restart_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    dram_if.dram_read_busy = 1'b0;
    dram_if.dram_buffer_full = 1'b0;
    test_reset();
    test_single();
    test_4k_split();
    test_back_to_back();
    test_throttle(1'b0);
    test_throttle(1'b1);
    test_error();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
